// File: rtl/imem_arb_if.sv
// Instruction-memory arbiter bus: fetch port, loader/debug port and the imem port.
interface imem_arb_if;
  localparam int unsigned XLEN = 32;

  // Fetch port
  logic            f_req;
  logic [XLEN-1:0] f_addr;
  logic            f_gnt;
  logic            f_rvalid;
  logic [XLEN-1:0] f_rdata;

  // Loader / debug port
  logic            l_req;
  logic            l_we;
  logic            l_lock;
  logic [XLEN-1:0] l_addr;
  logic [XLEN-1:0] l_wdata;
  logic            l_gnt;
  logic            l_rvalid;
  logic [XLEN-1:0] l_rdata;

  // Instruction memory port
  logic [XLEN-1:0] mem_a;
  logic            mem_we;
  logic [XLEN-1:0] mem_wd;
  logic [XLEN-1:0] mem_rd;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rd,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, mem_a, mem_we, mem_wd
  );

  // Requester / memory side
  modport master (
    output f_req, f_addr, l_req, l_we, l_lock, l_addr, l_wdata, mem_rd,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, mem_a, mem_we, mem_wd
  );
endinterface

// File: rtl/imem_arb.sv
// Two-port instruction-memory arbiter: fetch stage vs loader/debug, with a
// lockable loader burst mode and one-cycle registered read return.
// Optional macro IMEM_ARB_STARVE_EN adds loader starvation protection; without
// it SHARED is strict fetch priority.
module imem_arb #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  imem_arb_if.slave   bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    SHARED = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              f_gnt_c;
  logic              l_gnt_c;
  logic              l_rd_c;
  logic              starve_c;
  logic              f_rvalid_q, f_rvalid_d;
  logic              l_rvalid_q, l_rvalid_d;
  logic [XLEN-1:0]   f_rdata_q, f_rdata_d;
  logic [XLEN-1:0]   l_rdata_q, l_rdata_d;

`ifdef IMEM_ARB_STARVE_EN
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign starve_c = (cnt_q == MAX_WAIT_C);

  // Count consecutive denied loader cycles, saturating; any grant or idle clears.
  always_comb begin
    cnt_d = '0;
    if (bus.l_req && !l_gnt_c) begin
      cnt_d = starve_c ? cnt_q : CNT_W'(cnt_q + 1'b1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
  assign starve_c        = 1'b0;
`endif

  // Arbitration and lock FSM: grants are combinational and forced low in reset.
  always_comb begin
    state_d = state_q;
    f_gnt_c = 1'b0;
    l_gnt_c = 1'b0;
    if (!reset) begin
      case (state_q)
        SHARED: begin
          if (bus.l_req && (!bus.f_req || starve_c)) begin
            l_gnt_c = 1'b1;
          end else if (bus.f_req) begin
            f_gnt_c = 1'b1;
          end
          if (l_gnt_c && bus.l_lock) state_d = LOCKED;
        end
        LOCKED: begin
          l_gnt_c = bus.l_req;
          if (!bus.l_lock) state_d = SHARED;
        end
        default: state_d = SHARED;
      endcase
    end
  end

  // Read-return next state: capture imem data for the granted read only.
  always_comb begin
    l_rd_c     = l_gnt_c & ~bus.l_we;
    f_rvalid_d = f_gnt_c;
    l_rvalid_d = l_rd_c;
    f_rdata_d  = f_rdata_q;
    l_rdata_d  = l_rdata_q;
    if (f_gnt_c) f_rdata_d = bus.mem_rd;
    if (l_rd_c)  l_rdata_d = bus.mem_rd;
  end

  // State and read-return registers; async reset drops any pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SHARED;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      f_rvalid_q <= f_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      l_rdata_q  <= l_rdata_d;
    end
  end

  assign bus.f_gnt    = f_gnt_c;
  assign bus.l_gnt    = l_gnt_c;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.l_rvalid = l_rvalid_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.l_rdata  = l_rdata_q;
  assign bus.mem_a    = l_gnt_c ? bus.l_addr : bus.f_addr;
  assign bus.mem_we   = l_gnt_c & bus.l_we;
  assign bus.mem_wd   = bus.l_wdata;

endmodule
